alu_op_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_decode.sv | 21 ++
 rtl/alu_op_sequencer.sv | 136 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU operation sequencer: opcode map, MuxOut select
// bit order and FSM state encoding.
package alu_pkg;

    localparam int NUM_OPS = 7;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOT = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_ILL = 3'd7;

    // Bit positions of the one-hot select, in MuxOut input order.
    localparam int SEL_AND = 0;
    localparam int SEL_OR  = 1;
    localparam int SEL_XOR = 2;
    localparam int SEL_NOT = 3;
    localparam int SEL_ADD = 4;
    localparam int SEL_SUB = 5;
    localparam int SEL_MUL = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MWAIT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 3-bit opcode to MuxOut one-hot select plus
// an illegal-opcode flag. Illegal opcodes select nothing.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0]         opcode,
    output logic [NUM_OPS-1:0] onehot,
    output logic               illegal
);

    always_comb begin
        onehot  = '0;
        illegal = 1'b0;
        if (opcode == OP_ILL) begin
            illegal = 1'b1;
        end else begin
            onehot = NUM_OPS'(1) << opcode;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Operand/control stage ahead of MuxOut: accepts one op at a time, registers
// operands, drives the one-hot select and holds the result until taken.
//
// state | meaning
// IDLE  | ready for a new operation
// MWAIT | multiplier running, counting down its latency
// HOLD  | result valid, select and operands frozen until res_ready
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int K           = 7,
    parameter int MULT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   opcode,
    input  logic [K-1:0] a_in,
    input  logic [K-1:0] b_in,
    output logic [K-1:0] a_q,
    output logic [K-1:0] b_q,
    output logic [6:0]   sel,
    output logic         mult_start,
    output logic         res_valid,
    output logic         res_err,
    input  logic         res_ready
);

    localparam int CW = $clog2(MULT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [K-1:0]  a_d, b_d;
    logic [6:0]    sel_q, sel_d;
    logic          mult_start_q, mult_start_d;
    logic          res_valid_q, res_valid_d;
    logic          res_err_q, res_err_d;
    logic [6:0]    dec_onehot;
    logic          dec_illegal;
    logic [K-1:0]  a_q_r, b_q_r;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .onehot  (dec_onehot),
        .illegal (dec_illegal)
    );

    assign op_ready = !rst && (state_q == ST_IDLE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q_r;
        b_d          = b_q_r;
        sel_d        = sel_q;
        res_err_d    = res_err_q;
        mult_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (op_valid && op_ready) begin
                    a_d       = a_in;
                    b_d       = b_in;
                    sel_d     = dec_onehot;
                    res_err_d = dec_illegal;
                    if (opcode == OP_MUL) begin
                        mult_start_d = 1'b1;
                        if (MULT_CYCLES == 1) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_MWAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_MWAIT: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLD: begin
                cnt_d = '0;
                if (res_ready) begin
                    state_d   = ST_IDLE;
                    sel_d     = '0;
                    res_err_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                sel_d     = '0;
                res_err_d = 1'b0;
            end
        endcase
        res_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_q_r        <= '0;
            b_q_r        <= '0;
            sel_q        <= '0;
            mult_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q_r        <= a_d;
            b_q_r        <= b_d;
            sel_q        <= sel_d;
            mult_start_q <= mult_start_d;
            res_valid_q  <= res_valid_d;
            res_err_q    <= res_err_d;
        end
    end

    assign a_q        = a_q_r;
    assign b_q        = b_q_r;
    assign sel        = sel_q;
    assign mult_start = mult_start_q;
    assign res_valid  = res_valid_q;
    assign res_err    = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of single-cycle ops plus
// hand-written MUL, backpressure and reset-in-MWAIT sequences.
module tb_alu_op_sequencer;

    localparam int K = 7;
    localparam int MULT_CYCLES = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic         op_ready;
    logic [2:0]   opcode;
    logic [K-1:0] a_in, b_in, a_q, b_q;
    logic [6:0]   sel;
    logic         mult_start, res_valid, res_err, res_ready;

    int total = 0;
    int bad   = 0;

    alu_op_sequencer #(.K(K), .MULT_CYCLES(MULT_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .a_in       (a_in),
        .b_in       (b_in),
        .a_q        (a_q),
        .b_q        (b_q),
        .sel        (sel),
        .mult_start (mult_start),
        .res_valid  (res_valid),
        .res_err    (res_err),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [K-1:0] a;
        logic [K-1:0] b;
        logic [6:0]   exp_sel;
        logic         exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one op for a single edge, leaving the bench at the negedge after accept.
    task automatic issue(input logic [2:0] op, input logic [K-1:0] a, input logic [K-1:0] b);
        opcode   = op;
        a_in     = a;
        b_in     = b;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd0, 7'h55, 7'h0f, 7'b0000001, 1'b0};
        vecs[1] = '{3'd1, 7'h21, 7'h42, 7'b0000010, 1'b0};
        vecs[2] = '{3'd2, 7'h7f, 7'h01, 7'b0000100, 1'b0};
        vecs[3] = '{3'd3, 7'h33, 7'h00, 7'b0001000, 1'b0};
        vecs[4] = '{3'd4, 7'h12, 7'h05, 7'b0010000, 1'b0};
        vecs[5] = '{3'd5, 7'h40, 7'h3c, 7'b0100000, 1'b0};
        vecs[6] = '{3'd7, 7'h0a, 7'h0b, 7'b0000000, 1'b1};

        rst = 1'b1; op_valid = 1'b0; opcode = '0; a_in = '0; b_in = '0; res_ready = 1'b0;
        step();
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_op_ready_after", 32'(op_ready), 32'd1);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_a_q", 32'(a_q), 32'd0);
        chk("rst_b_q", 32'(b_q), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);

        res_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            chk("vec_res_valid", 32'(res_valid), 32'd1);
            chk("vec_sel", 32'(sel), 32'(vecs[i].exp_sel));
            chk("vec_err", 32'(res_err), 32'(vecs[i].exp_err));
            chk("vec_a_q", 32'(a_q), 32'(vecs[i].a));
            chk("vec_b_q", 32'(b_q), 32'(vecs[i].b));
            chk("vec_op_ready_busy", 32'(op_ready), 32'd0);
            step();
            chk("vec_done_valid", 32'(res_valid), 32'd0);
            chk("vec_done_sel", 32'(sel), 32'd0);
            chk("vec_done_err", 32'(res_err), 32'd0);
            chk("vec_done_ready", 32'(op_ready), 32'd1);
            chk("vec_done_a_kept", 32'(a_q), 32'(vecs[i].a));
        end

        // MUL: start pulse at T+1 only, result at T+MULT_CYCLES, stray op ignored.
        res_ready = 1'b0;
        issue(3'd6, 7'h09, 7'h03);
        chk("mul_start_t1", 32'(mult_start), 32'd1);
        chk("mul_valid_t1", 32'(res_valid), 32'd0);
        chk("mul_sel_t1", 32'(sel), 32'b1000000);
        chk("mul_ready_t1", 32'(op_ready), 32'd0);
        opcode = 3'd0; a_in = 7'h7e; b_in = 7'h7d; op_valid = 1'b1; res_ready = 1'b1;
        step();
        chk("mul_start_t2", 32'(mult_start), 32'd0);
        chk("mul_valid_t2", 32'(res_valid), 32'd0);
        step();
        chk("mul_valid_t3", 32'(res_valid), 32'd0);
        chk("mul_start_t3", 32'(mult_start), 32'd0);
        op_valid = 1'b0; res_ready = 1'b0;
        step();
        chk("mul_valid_t4", 32'(res_valid), 32'd1);
        chk("mul_sel_t4", 32'(sel), 32'b1000000);
        chk("mul_a_q", 32'(a_q), 32'h09);
        chk("mul_b_q", 32'(b_q), 32'h03);
        res_ready = 1'b1;
        step();
        chk("mul_done_valid", 32'(res_valid), 32'd0);
        chk("mul_done_ready", 32'(op_ready), 32'd1);

        // Backpressure on OR.
        res_ready = 1'b0;
        issue(3'd1, 7'h2a, 7'h15);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_sel", 32'(sel), 32'b0000010);
            chk("bp_a_q", 32'(a_q), 32'h2a);
            chk("bp_b_q", 32'(b_q), 32'h15);
            chk("bp_op_ready", 32'(op_ready), 32'd0);
            step();
        end
        res_ready = 1'b1;
        chk("bp_last_valid", 32'(res_valid), 32'd1);
        step();
        chk("bp_done_valid", 32'(res_valid), 32'd0);
        chk("bp_done_sel", 32'(sel), 32'd0);

        // Reset while MUL is in MWAIT.
        issue(3'd6, 7'h11, 7'h22);
        step();
        rst = 1'b1;
        chk("rstmw_op_ready_in_rst", 32'(op_ready), 32'd0);
        step();
        chk("rstmw_sel", 32'(sel), 32'd0);
        chk("rstmw_valid", 32'(res_valid), 32'd0);
        chk("rstmw_start", 32'(mult_start), 32'd0);
        chk("rstmw_err", 32'(res_err), 32'd0);
        chk("rstmw_a_q", 32'(a_q), 32'd0);
        chk("rstmw_b_q", 32'(b_q), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rstmw_no_valid", 32'(res_valid), 32'd0);
            chk("rstmw_no_start", 32'(mult_start), 32'd0);
        end
        issue(3'd4, 7'h12, 7'h05);
        chk("post_add_valid", 32'(res_valid), 32'd1);
        chk("post_add_sel", 32'(sel), 32'b0010000);
        chk("post_add_a_q", 32'(a_q), 32'h12);
        step();
        chk("post_add_idle", 32'(op_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
